// File: rtl/uart_tx_core.sv
// UART transmitter: serialises one byte per frame (start, data, optional parity, stop)
// using a per-frame snapshot of the tuner settings.
module uart_tx_core #(
    parameter int DATA_W = 8,
    parameter int PW_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PW_W-1:0]   pulse_width,
    input  logic [1:0]        sbl,
    input  logic              parity_on,
    input  logic              parity_set,
    input  logic              seniority_h,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the plain XOR; odd parity is its inverse.
    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic even);
        parity_of = (^d) ^ ~even;
    endfunction

    state_t              state_r, state_n;
    logic [PW_W:0]       timer_r, timer_n;
    logic [BW-1:0]       bit_r, bit_n;
    logic [DATA_W-1:0]   shift_r, shift_n;
    logic [PW_W-1:0]     p_r;
    logic [PW_W:0]       stop_len_r;
    logic                par_on_r, msb_first_r, par_bit_r;

    logic [PW_W-1:0]     p_in_s;
    logic [PW_W:0]       stop_in_s;
    logic [PW_W:0]       len_s;
    logic                accept_s, last_s;
    logic                tx_n, done_n, ready_n;

    // Clamp bit period and derive stop length from the live settings (used only at accept).
    always_comb begin
        p_in_s = (pulse_width < PW_W'(2)) ? PW_W'(2) : pulse_width;
        case (sbl)
            2'd1:    stop_in_s = {1'b0, p_in_s} + {2'b00, p_in_s[PW_W-1:1]};
            2'd2:    stop_in_s = {p_in_s, 1'b0};
            default: stop_in_s = {1'b0, p_in_s};
        endcase
    end

    assign accept_s = valid && ready;
    assign len_s    = (state_r == STOP) ? stop_len_r : {1'b0, p_r};
    assign last_s   = (timer_r == (len_s - (PW_W+1)'(1)));

    // Next-state, bit counter and shift register.
    always_comb begin
        state_n = state_r;
        timer_n = timer_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = START;
                    timer_n = '0;
                    bit_n   = '0;
                    shift_n = data;
                end else begin
                    state_n = IDLE;
                end
            end
            START, DATA, PARITY, STOP: begin
                if (!last_s) begin
                    timer_n = timer_r + (PW_W+1)'(1);
                end else begin
                    timer_n = '0;
                    case (state_r)
                        START:  state_n = DATA;
                        DATA: begin
                            if (bit_r == BW'(DATA_W-1)) begin
                                state_n = par_on_r ? PARITY : STOP;
                                bit_n   = '0;
                            end else begin
                                bit_n   = bit_r + BW'(1);
                                shift_n = msb_first_r ? {shift_r[DATA_W-2:0], 1'b0}
                                                      : {1'b0, shift_r[DATA_W-1:1]};
                            end
                        end
                        PARITY: state_n = STOP;
                        default: state_n = IDLE;
                    endcase
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                bit_n   = '0;
            end
        endcase
    end

    // Outputs are computed for the upcoming cycle so tx falls on the accepting edge.
    always_comb begin
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = msb_first_r ? shift_n[DATA_W-1] : shift_n[0];
            PARITY:  tx_n = par_bit_r;
            default: tx_n = 1'b1;
        endcase
        done_n  = (state_n == STOP) && (timer_n == (stop_len_r - (PW_W+1)'(1)));
        ready_n = (state_n == IDLE);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            timer_r <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_r <= state_n;
            timer_r <= timer_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            tx      <= tx_n;
            ready   <= ready_n;
            done    <= done_n;
        end
    end

    // Frame snapshot of the settings, captured only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r         <= PW_W'(2);
            stop_len_r  <= (PW_W+1)'(2);
            par_on_r    <= 1'b0;
            msb_first_r <= 1'b0;
            par_bit_r   <= 1'b0;
        end else if (accept_s) begin
            p_r         <= p_in_s;
            stop_len_r  <= stop_in_s;
            par_on_r    <= parity_on;
            msb_first_r <= seniority_h;
            par_bit_r   <= parity_of(data, parity_set);
        end else begin
            p_r         <= p_r;
            stop_len_r  <= stop_len_r;
            par_on_r    <= par_on_r;
            msb_first_r <= msb_first_r;
            par_bit_r   <= par_bit_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core: frame shapes, parity, stop lengths,
// period clamping, setting snapshots, back-to-back frames and mid-frame reset.
module tb_uart_tx_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] pulse_width = 24'd4;
    logic [1:0]  sbl = 2'd0;
    logic        parity_on = 1'b0;
    logic        parity_set = 1'b0;
    logic        seniority_h = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready, tx, done;

    logic tx_tr   [0:159];
    logic done_tr [0:159];
    logic rdy_tr  [0:159];

    int checks = 0;
    int failures = 0;

    uart_tx_core #(.DATA_W(8), .PW_W(24)) dut (
        .clk(clk), .rst(rst), .pulse_width(pulse_width), .sbl(sbl),
        .parity_on(parity_on), .parity_set(parity_set), .seniority_h(seniority_h),
        .data(data), .valid(valid), .ready(ready), .tx(tx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic start_frame(input logic [7:0] d, input logic [23:0] pw, input logic [1:0] s,
                               input logic po, input logic ps, input logic sh);
        @(negedge clk);
        data = d; pulse_width = pw; sbl = s;
        parity_on = po; parity_set = ps; seniority_h = sh;
        valid = 1'b1;
        @(posedge clk);
    endtask

    // Records tx/done/ready for cycles 0..n after the accepting edge.
    task automatic capture(input int n, input int drop_at, input bit chg,
                           input logic [7:0] nd, input logic [23:0] npw, input logic [1:0] nsbl);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            tx_tr[c] = tx; done_tr[c] = done; rdy_tr[c] = ready;
            if (c == drop_at) valid = 1'b0;
            if (c == 0 && chg) begin
                data = nd; pulse_width = npw; sbl = nsbl;
            end
        end
    endtask

    // Expected tx: level lv[k] for k-th P-cycle slot, then high through stop.
    function automatic int first_bad(input logic [15:0] lv, input int nlev, input int p,
                                     input int off, input int total);
        logic e;
        for (int c = 0; c < total; c++) begin
            e = (c < nlev * p) ? lv[c / p] : 1'b1;
            if (tx_tr[off + c] !== e) return c;
        end
        return -1;
    endfunction

    task automatic chk_frame(input string name, input logic [15:0] lv, input int nlev,
                             input int p, input int total);
        int bad;
        checks++;
        bad = first_bad(lv, nlev, p, 0, total);
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_tx cycle=%0d got=%b required=%b", name, bad, tx_tr[bad], ~tx_tr[bad]);
        end
        checks++;
        bad = -1;
        for (int c = 0; c <= total; c++) if (bad < 0 && done_tr[c] !== (c == total - 1)) bad = c;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_done cycle=%0d got=%b required=%b", name, bad, done_tr[bad], (bad == total - 1));
        end
        checks++;
        bad = -1;
        for (int c = 0; c <= total; c++) if (bad < 0 && rdy_tr[c] !== (c == total)) bad = c;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_ready cycle=%0d got=%b required=%b", name, bad, rdy_tr[bad], (bad == total));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, ready, done} !== 3'b110) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=110", {tx, ready, done});
        end
        valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx, ready, done} !== 3'b110) begin
            failures++;
            $display("FAIL reset_release got=%b required=110", {tx, ready, done});
        end
    endtask

    task automatic test_lsb_no_parity();
        start_frame(8'hA5, 24'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        capture(40, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        chk_frame("a5_lsb", 16'b101001010, 9, 4, 40);
    endtask

    task automatic test_msb_even_parity();
        start_frame(8'h81, 24'd4, 2'd0, 1'b1, 1'b1, 1'b1);
        capture(44, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        chk_frame("81_msb_even", 16'b0100000010, 10, 4, 44);
    endtask

    task automatic test_odd_parity_one_half();
        start_frame(8'h00, 24'd3, 2'd1, 1'b1, 1'b0, 1'b0);
        capture(34, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        chk_frame("00_odd_1p5", 16'b1000000000, 10, 3, 34);
    endtask

    task automatic test_clamp_two_stop();
        start_frame(8'hFF, 24'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        capture(22, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        chk_frame("ff_pw0", 16'b111111110, 9, 2, 22);
        start_frame(8'hFF, 24'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        capture(22, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        chk_frame("ff_pw1", 16'b111111110, 9, 2, 22);
    endtask

    task automatic test_back_to_back();
        int bad;
        start_frame(8'h3C, 24'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        capture(129, 41, 1'b1, 8'hC3, 24'd8, 2'd2);
        checks++;
        bad = first_bad(16'b001111000, 9, 4, 0, 40);
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_first_tx cycle=%0d got=%b required=%b", bad, tx_tr[bad], ~tx_tr[bad]);
        end
        checks++;
        if ({tx_tr[40], rdy_tr[40]} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_idle_gap got=%b required=11", {tx_tr[40], rdy_tr[40]});
        end
        checks++;
        bad = first_bad(16'b110000110, 9, 8, 41, 88);
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_second_tx cycle=%0d got=%b required=%b", bad, tx_tr[41 + bad], ~tx_tr[41 + bad]);
        end
        checks++;
        bad = -1;
        for (int c = 0; c <= 129; c++) if (bad < 0 && done_tr[c] !== (c == 39 || c == 128)) bad = c;
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_done cycle=%0d got=%b required=%b", bad, done_tr[bad], (bad == 39 || bad == 128));
        end
        checks++;
        bad = -1;
        for (int c = 0; c <= 129; c++) if (bad < 0 && rdy_tr[c] !== (c == 40 || c == 129)) bad = c;
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_ready cycle=%0d got=%b required=%b", bad, rdy_tr[bad], (bad == 40 || bad == 129));
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        start_frame(8'h55, 24'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        capture(9, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        checks++;
        if ({tx_tr[9], rdy_tr[9]} !== 2'b00) begin
            failures++;
            $display("FAIL rst_pre_data got=%b required=00", {tx_tr[9], rdy_tr[9]});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx, ready, done} !== 3'b110) begin
            failures++;
            $display("FAIL rst_immediate got=%b required=110", {tx, ready, done});
        end
        valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({tx, ready, done} !== 3'b110) bad = 1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_hold got=%b required=110", {tx, ready, done});
        end
        valid = 1'b0; rst = 1'b0;
        start_frame(8'hA5, 24'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        capture(40, 0, 1'b0, 8'h00, 24'd0, 2'd0);
        chk_frame("after_rst", 16'b101001010, 9, 4, 40);
    endtask

    initial begin
        test_reset();
        test_lsb_no_parity();
        test_msb_even_parity();
        test_odd_parity_one_half();
        test_clamp_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Serial transmitter stage that sits directly downstream of the UART settings tuner.
- Consumes the tuner's stored settings (pulse_width, sbl, parity_on, parity_set, seniority_h) and serialises parallel bytes onto the tx line.
- Its ready output forms the TX half of the tuner's "condition" input, so settings only change between frames.
- Settings are snapshotted at frame accept and held constant for the whole frame.

Parameters:
- DATA_W, 8, payload bits per frame.
- PW_W, 24, width of pulse_width (clock cycles per bit).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- pulse_width  input  PW_W  clocks per bit, from tuner settings.
- sbl  input  2  stop-bit length: 0=ONE, 1=ONE_AND_HALF, 2=TWO, 3 treated as ONE.
- parity_on  input  1  1 = parity bit present.
- parity_set  input  1  1 = even parity, 0 = odd parity.
- seniority_h  input  1  1 = MSB first, 0 = LSB first.
- data  input  DATA_W  byte to send.
- valid  input  1  data valid.
- ready  output  1  core idle and able to accept.
- tx  output  1  serial line, idle high.
- done  output  1  one-cycle pulse at end of the last stop-bit cycle.

Behaviour:
- Reset values (async, immediate): state=IDLE, tx=1, ready=1, done=0, bit timer=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame immediately: tx returns high the same instant; no done pulse.
- Handshake:
  - Accept occurs on a rising edge where valid && ready.
  - On accept, register data, pulse_width, sbl, parity_on, parity_set and seniority_h into a frame snapshot.
  - ready falls on that same edge.
  - Input changes after accept have no effect on the frame in progress.
- Effective bit period: P = max(snapshot pulse_width, 2).
- Parity bit:
  - Even (parity_set=1): XOR of the data bits.
  - Odd (parity_set=0): the inverse of that XOR.
- State machine (bit timer counts 0..len-1; state advances when the timer reaches len-1):
  - IDLE: tx=1, ready=1. On accept, go to START.
  - START: tx=0 for P cycles, then go to DATA.
  - DATA: DATA_W bits, each lasting P cycles.
    - seniority_h=0: bit 0 first.
    - seniority_h=1: bit DATA_W-1 first.
    - After the last bit, go to PARITY if parity_on, else STOP.
  - PARITY: tx=parity bit for P cycles, then go to STOP.
  - STOP: tx=1 for a length set by sbl, then go to IDLE.
    - ONE: P cycles.
    - ONE_AND_HALF: P + (P>>1) cycles.
    - TWO: 2P cycles.
    - done=1 in the final STOP cycle.
- Latency and timing:
  - tx goes low on the clock edge that accepts the byte.
  - Total frame = (1 + DATA_W + parity_on)*P + stop_len cycles.
  - ready returns high on the edge after the last STOP cycle.
  - Back-to-back: valid held high lets a new accept occur on the first IDLE cycle, so there is exactly one idle-high cycle between frames.
- Settings changes while ready=0 are ignored until the next accept.
- valid=1 during reset is ignored.

Test Plan:
- pulse_width=4, sbl=ONE, parity_on=0, seniority_h=0, data=0xA5 -> tx (each level held 4 cycles): 0, 1,0,1,0,0,1,0,1, 1. Frame = 40 cycles; done pulses at cycle 39 after accept; ready high at cycle 40.
- Same settings with seniority_h=1, parity_on=1, parity_set=1, data=0x81 -> data bits 1,0,0,0,0,0,0,1, parity=0, one stop. Frame = 44 cycles.
- parity_set=0, data=0x00, pulse_width=3 -> parity bit = 1. sbl=ONE_AND_HALF gives stop = 4 cycles. Frame = 3*10 + 4 = 34 cycles.
- pulse_width=0 or 1, sbl=TWO, data=0xFF -> P clamped to 2. Frame = 2*9 + 4 = 22 cycles.
- Change pulse_width 4->8 and sbl mid-frame -> frame finishes with the old values. valid held high -> next frame uses the new values after exactly 1 idle-high cycle.
- Assert rst in the DATA state -> tx=1 and ready=1 immediately, no done pulse. After release, a new byte transmits correctly.
